// File: rtl/framebuffer_tile_responder_pkg.sv
// Shared types and constants for the tile buffer channel responder.
package framebuffer_tile_responder_pkg;

  // Clear sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } clear_state_t;

  // Word widths of the three channel flavours.
  localparam int COLOR_DATA_WIDTH   = 32;
  localparam int DEPTH_DATA_WIDTH   = 16;
  localparam int STENCIL_DATA_WIDTH = 4;

endpackage

// File: rtl/framebuffer_tile_responder_index_scoreboard.sv
// In-order FIFO of in-flight read indices with a parallel match port.
// The caller guarantees push only when not full and pop only when not empty,
// so the slots touched by a same-cycle push and pop never coincide.
module framebuffer_tile_responder_index_scoreboard #(
  parameter int INDEX_WIDTH = 14,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [INDEX_WIDTH-1:0] push_index,
  input  logic                   pop,
  input  logic [INDEX_WIDTH-1:0] match_index,
  output logic                   match,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  logic [INDEX_WIDTH-1:0] entries [DEPTH];
  logic [DEPTH-1:0]       valid;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;

  // Slot occupancy and pointers; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
    end
  end

  // Index storage; contents are meaningful only where valid is set.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= push_index;
  end

  // Parallel compare of the request index against every live entry.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i] == match_index)) match = 1'b1;
    end
  end

  assign full  = &valid;
  assign empty = ~|valid;

endmodule

// File: rtl/framebuffer_tile_responder.sv
// Memory-side responder for one tile buffer channel: read stream with
// read-after-write protection, in-order write-back, and a full clear sequencer.
//
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// producer holds payload stable while valid && !ready, and the consumer side
// (rvalid/rdata) likewise holds until rready.
module framebuffer_tile_responder
  import framebuffer_tile_responder_pkg::*;
#(
  parameter int INDEX_WIDTH    = 14,
  parameter int DATA_WIDTH     = COLOR_DATA_WIDTH,
  parameter int INFLIGHT_DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  confClearValue,
  input  logic                   clear_start,
  output logic                   clear_busy,
  input  logic                   req_tvalid,
  output logic                   req_tready,
  input  logic [INDEX_WIDTH-1:0] req_tindex,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [DATA_WIDTH-1:0]  rdata,
  input  logic [INDEX_WIDTH-1:0] waddr,
  input  logic                   wvalid,
  input  logic                   wstrb,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   wlast,
  output logic                   frame_done,
  output logic                   protocol_error,
  output clear_state_t           fsm_state
);

  localparam int MEM_DEPTH = 2 ** INDEX_WIDTH;
  localparam logic [INDEX_WIDTH:0] LAST_INDEX = (INDEX_WIDTH + 1)'(MEM_DEPTH - 1);

  clear_state_t          state, next_state;
  logic [INDEX_WIDTH:0]  clear_count, next_count;
  logic                  clear_we;

  logic                  sb_match, sb_full, sb_empty;
  logic                  req_fire, sb_pop;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rd_stage;

  logic [DATA_WIDTH-1:0] ofifo [2];
  logic                  ofifo_wr, ofifo_rd;
  logic [1:0]            ofifo_count;
  logic                  ofifo_pop;

  // Admission counts reads already committed to the output FIFO, so it can never overflow.
  assign req_tready = !reset && (state == ST_IDLE) &&
                      (({1'b0, ofifo_count} + {2'b0, rd_stage}) < 3'd2) &&
                      !sb_full && !sb_match;
  assign req_fire   = req_tvalid && req_tready;
  assign sb_pop     = wvalid && !sb_empty;

  framebuffer_tile_responder_index_scoreboard #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .DEPTH       (INFLIGHT_DEPTH)
  ) u_scoreboard (
    .clk         (aclk),
    .rst         (reset),
    .push        (req_fire),
    .push_index  (req_tindex),
    .pop         (sb_pop),
    .match_index (req_tindex),
    .match       (sb_match),
    .full        (sb_full),
    .empty       (sb_empty)
  );

  // Single-port-write RAM: clear owns the write port while sweeping.
  always_ff @(posedge aclk) begin
    if (clear_we) begin
      mem[clear_count[INDEX_WIDTH-1:0]] <= confClearValue;
    end else if (wvalid && wstrb) begin
      mem[waddr] <= wdata;
    end
    if (req_fire) mem_rdata <= mem[req_tindex];
  end

  // Tracks a read sitting in the memory stage.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) rd_stage <= 1'b0;
    else       rd_stage <= req_fire;
  end

  assign ofifo_pop = rvalid && rready;

  // Two-entry output FIFO holding read data until the consumer takes it.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) ofifo[i] <= '0;
      ofifo_wr    <= 1'b0;
      ofifo_rd    <= 1'b0;
      ofifo_count <= 2'd0;
    end else begin
      if (rd_stage) begin
        ofifo[ofifo_wr] <= mem_rdata;
        ofifo_wr        <= ~ofifo_wr;
      end
      if (ofifo_pop) ofifo_rd <= ~ofifo_rd;
      case ({rd_stage, ofifo_pop})
        2'b10:   ofifo_count <= ofifo_count + 2'd1;
        2'b01:   ofifo_count <= ofifo_count - 2'd1;
        default: ofifo_count <= ofifo_count;
      endcase
    end
  end

  assign rvalid = (ofifo_count != 2'd0);
  assign rdata  = ofifo[ofifo_rd];

  // Write-back status flags: sticky protocol error and end-of-primitive pulse.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      protocol_error <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      if (wvalid && sb_empty) protocol_error <= 1'b1;
      frame_done <= wvalid && wlast;
    end
  end

  // Clear sequencer state and sweep counter.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      clear_count <= '0;
    end else begin
      state       <= next_state;
      clear_count <= next_count;
    end
  end

  // Clear sequencer transitions: drain outstanding reads, then sweep every index once.
  always_comb begin
    next_state = state;
    next_count = clear_count;
    clear_we   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear_start) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (sb_empty && (ofifo_count == 2'd0) && !rd_stage) begin
          next_state = ST_CLEAR;
          next_count = '0;
        end
      end
      ST_CLEAR: begin
        clear_we = 1'b1;
        if (clear_count == LAST_INDEX) next_state = ST_IDLE;
        else                           next_count = clear_count + 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign clear_busy = (state != ST_IDLE);
  assign fsm_state  = state;

endmodule

// File: tb/tb_framebuffer_tile_responder.sv
// Directed bench for framebuffer_tile_responder with a 16-entry buffer.
module tb_framebuffer_tile_responder;
  import framebuffer_tile_responder_pkg::*;

  localparam int IW = 4;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          reset;
  logic [DW-1:0] confClearValue;
  logic          clear_start;
  logic          clear_busy;
  logic          req_tvalid;
  logic          req_tready;
  logic [IW-1:0] req_tindex;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [IW-1:0] waddr;
  logic          wvalid;
  logic          wstrb;
  logic [DW-1:0] wdata;
  logic          wlast;
  logic          frame_done;
  logic          protocol_error;
  clear_state_t  fsm_state;

  int checks = 0;
  int errors = 0;

  framebuffer_tile_responder #(
    .INDEX_WIDTH    (IW),
    .DATA_WIDTH     (DW),
    .INFLIGHT_DEPTH (4)
  ) dut (
    .aclk           (aclk),
    .reset          (reset),
    .confClearValue (confClearValue),
    .clear_start    (clear_start),
    .clear_busy     (clear_busy),
    .req_tvalid     (req_tvalid),
    .req_tready     (req_tready),
    .req_tindex     (req_tindex),
    .rvalid         (rvalid),
    .rready         (rready),
    .rdata          (rdata),
    .waddr          (waddr),
    .wvalid         (wvalid),
    .wstrb          (wstrb),
    .wdata          (wdata),
    .wlast          (wlast),
    .frame_done     (frame_done),
    .protocol_error (protocol_error),
    .fsm_state      (fsm_state)
  );

  // Clock
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic send_req(input logic [IW-1:0] idx, input string tag);
    int n;
    n = 0;
    req_tvalid = 1'b1;
    req_tindex = idx;
    settle();
    while (!req_tready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_accept"}, {31'd0, req_tready}, 32'd1);
    tick();
    req_tvalid = 1'b0;
    settle();
  endtask

  // Wait for read data (bounded), compare, and let it pop.
  task automatic wait_rdata(input logic [DW-1:0] exp, input string tag);
    int n;
    n = 0;
    while (!rvalid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    chk({tag, "_rdata"}, rdata, exp);
    tick();
  endtask

  task automatic write_back(input logic [IW-1:0] idx, input logic [DW-1:0] data, input logic strb);
    wvalid = 1'b1;
    waddr  = idx;
    wdata  = data;
    wstrb  = strb;
    tick();
    wvalid = 1'b0;
    wstrb  = 1'b0;
    settle();
  endtask

  // Load a known word: read (result discarded), then commit the write-back.
  task automatic prime(input logic [IW-1:0] idx, input logic [DW-1:0] data);
    send_req(idx, "prime");
    tick();
    tick();
    tick();
    write_back(idx, data, 1'b1);
  endtask

  task automatic read_check(input logic [IW-1:0] idx, input logic [DW-1:0] exp, input string tag);
    send_req(idx, tag);
    wait_rdata(exp, tag);
    write_back(idx, '0, 1'b0);
  endtask

  logic [IW-1:0] prime_idx [6];
  logic [DW-1:0] prime_val [6];

  initial begin
    prime_idx = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8};
    prime_val = '{32'hDEADBEEF, 32'h101, 32'h102, 32'h103, 32'h104, 32'h108};

    reset = 1'b1;
    confClearValue = 32'hA5;
    clear_start = 1'b0;
    req_tvalid = 1'b0;
    req_tindex = '0;
    rready = 1'b1;
    waddr = '0;
    wvalid = 1'b0;
    wstrb = 1'b0;
    wdata = '0;
    wlast = 1'b0;

    // Reset values
    tick();
    req_tvalid = 1'b1;
    settle();
    chk("rst_req_tready", {31'd0, req_tready}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_protocol_error", {31'd0, protocol_error}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    req_tvalid = 1'b0;
    tick();
    reset = 1'b0;
    settle();

    for (int i = 0; i < 6; i++) prime(prime_idx[i], prime_val[i]);

    // Single read: rvalid two cycles after acceptance
    req_tvalid = 1'b1;
    req_tindex = 4'd5;
    settle();
    chk("t1_ready_c0", {31'd0, req_tready}, 32'd1);
    tick();
    req_tvalid = 1'b0;
    req_tindex = 4'd6;
    settle();
    chk("t1_rvalid_c1", {31'd0, rvalid}, 32'd0);
    chk("t1_ready_c1", {31'd0, req_tready}, 32'd1);
    tick();
    chk("t1_rvalid_c2", {31'd0, rvalid}, 32'd1);
    chk("t1_rdata_c2", rdata, 32'hDEADBEEF);
    chk("t1_ready_c2", {31'd0, req_tready}, 32'd1);
    tick();
    chk("t1_rvalid_c3", {31'd0, rvalid}, 32'd0);
    write_back(4'd5, '0, 1'b0);

    // Read-after-write hazard on index 7
    req_tvalid = 1'b1;
    req_tindex = 4'd7;
    settle();
    chk("t2_first_ready", {31'd0, req_tready}, 32'd1);
    tick();
    chk("t2_hazard_stall", {31'd0, req_tready}, 32'd0);
    tick();
    wvalid = 1'b1;
    waddr = 4'd7;
    wdata = 32'h11;
    wstrb = 1'b1;
    settle();
    chk("t2_prepop_stall", {31'd0, req_tready}, 32'd0);
    tick();
    wvalid = 1'b0;
    wstrb = 1'b0;
    settle();
    chk("t2_after_pop", {31'd0, req_tready}, 32'd1);
    tick();
    req_tvalid = 1'b0;
    settle();
    wait_rdata(32'h11, "t2_second");
    write_back(4'd7, '0, 1'b0);

    // Back-pressure: only two reads admitted, data held stable
    rready = 1'b0;
    req_tvalid = 1'b1;
    req_tindex = 4'd1;
    settle();
    chk("t3_ready_req1", {31'd0, req_tready}, 32'd1);
    tick();
    req_tindex = 4'd2;
    settle();
    chk("t3_ready_req2", {31'd0, req_tready}, 32'd1);
    tick();
    req_tindex = 4'd3;
    settle();
    chk("t3_stall_req3", {31'd0, req_tready}, 32'd0);
    tick();
    req_tindex = 4'd4;
    settle();
    chk("t3_stall_req4", {31'd0, req_tready}, 32'd0);
    chk("t3_rvalid_held", {31'd0, rvalid}, 32'd1);
    chk("t3_rdata_held_a", rdata, 32'h101);
    tick();
    chk("t3_stall_req4_b", {31'd0, req_tready}, 32'd0);
    chk("t3_rdata_held_b", rdata, 32'h101);
    req_tvalid = 1'b0;
    rready = 1'b1;
    settle();
    chk("t3_pop1_rdata", rdata, 32'h101);
    tick();
    chk("t3_pop2_rvalid", {31'd0, rvalid}, 32'd1);
    chk("t3_pop2_rdata", rdata, 32'h102);
    tick();
    chk("t3_drained", {31'd0, rvalid}, 32'd0);
    write_back(4'd1, '0, 1'b0);
    write_back(4'd2, '0, 1'b0);

    // Scoreboard full: fifth request waits for a no-strobe write-back
    send_req(4'd8, "t4_r8");
    send_req(4'd9, "t4_r9");
    send_req(4'd10, "t4_r10");
    send_req(4'd11, "t4_r11");
    tick();
    tick();
    tick();
    req_tvalid = 1'b1;
    req_tindex = 4'd12;
    settle();
    chk("t4_full_stall_a", {31'd0, req_tready}, 32'd0);
    tick();
    chk("t4_full_stall_b", {31'd0, req_tready}, 32'd0);
    wvalid = 1'b1;
    waddr = 4'd8;
    wdata = 32'hBAD;
    wstrb = 1'b0;
    settle();
    chk("t4_prepop_stall", {31'd0, req_tready}, 32'd0);
    tick();
    wvalid = 1'b0;
    settle();
    chk("t4_after_pop", {31'd0, req_tready}, 32'd1);
    tick();
    req_tvalid = 1'b0;
    tick();
    tick();
    tick();
    write_back(4'd9, '0, 1'b0);
    write_back(4'd10, '0, 1'b0);
    write_back(4'd11, '0, 1'b0);
    write_back(4'd12, '0, 1'b0);
    read_check(4'd8, 32'h108, "t4_mem_unchanged");
    chk("t4_no_protocol_error", {31'd0, protocol_error}, 32'd0);

    // Clear with one read in flight
    send_req(4'd3, "t5_inflight");
    tick();
    tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    req_tvalid = 1'b1;
    req_tindex = 4'd0;
    settle();
    chk("t5_busy_drain", {31'd0, clear_busy}, 32'd1);
    chk("t5_state_drain", 32'(fsm_state), 32'(ST_DRAIN));
    chk("t5_no_accept_drain", {31'd0, req_tready}, 32'd0);
    tick();
    tick();
    chk("t5_still_drain", 32'(fsm_state), 32'(ST_DRAIN));
    req_tvalid = 1'b0;
    write_back(4'd3, 32'h33, 1'b1);
    chk("t5_drain_last", 32'(fsm_state), 32'(ST_DRAIN));
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("t5_clearing", 32'(fsm_state), 32'(ST_CLEAR));
      clear_start = (k == 5);
      settle();
      tick();
    end
    clear_start = 1'b0;
    settle();
    chk("t5_done_busy", {31'd0, clear_busy}, 32'd0);
    chk("t5_done_state", 32'(fsm_state), 32'(ST_IDLE));
    tick();
    chk("t5_no_restart", 32'(fsm_state), 32'(ST_IDLE));
    for (int i = 0; i < 16; i++) read_check(IW'(i), 32'hA5, "t5_cleared");

    // Write-back with empty scoreboard, frame_done pulse
    wvalid = 1'b1;
    waddr = 4'd0;
    wstrb = 1'b0;
    wlast = 1'b1;
    settle();
    chk("t6_pe_before", {31'd0, protocol_error}, 32'd0);
    chk("t6_fd_before", {31'd0, frame_done}, 32'd0);
    tick();
    wvalid = 1'b0;
    wlast = 1'b0;
    settle();
    chk("t6_pe_set", {31'd0, protocol_error}, 32'd1);
    chk("t6_fd_pulse", {31'd0, frame_done}, 32'd1);
    tick();
    chk("t6_fd_low", {31'd0, frame_done}, 32'd0);
    chk("t6_pe_sticky", {31'd0, protocol_error}, 32'd1);

    // Reset in the middle of a clear
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    tick();
    tick();
    tick();
    chk("t7_in_clear", 32'(fsm_state), 32'(ST_CLEAR));
    req_tvalid = 1'b1;
    req_tindex = 4'd2;
    reset = 1'b1;
    settle();
    chk("t7_busy_low", {31'd0, clear_busy}, 32'd0);
    chk("t7_ready_low", {31'd0, req_tready}, 32'd0);
    chk("t7_state_idle", 32'(fsm_state), 32'(ST_IDLE));
    chk("t7_pe_cleared", {31'd0, protocol_error}, 32'd0);
    tick();
    reset = 1'b0;
    settle();
    chk("t7_ready_after", {31'd0, req_tready}, 32'd1);
    req_tvalid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_tile_responder.md
Name: framebuffer_tile_responder

Overview:
- Memory-side partner of the per-fragment stage for one on-chip tile buffer channel (color, depth or stencil; instantiated once per channel).
- Serves the read stream (rvalid/rready/rdata) against an upstream index request stream.
- Accepts the write-back stream (waddr/wvalid/wstrb/wdata/wlast).
- Enforces read-after-write ordering for indices still in flight and provides a full-buffer clear sequencer.

Parameters:
- INDEX_WIDTH, 14, framebuffer index width; buffer depth = 2**INDEX_WIDTH.
- DATA_WIDTH, 32, word width (32 color, 16 depth, 4 stencil).
- INFLIGHT_DEPTH, 4, scoreboard entries; must be a power of two, >= 2.

Ports:
- aclk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- confClearValue  in  DATA_WIDTH  value written by clear
- clear_start  in  1  one-cycle clear request
- clear_busy  out  1  high while draining or clearing
- req_tvalid  in  1  read request valid
- req_tready  out  1  read request accepted
- req_tindex  in  INDEX_WIDTH  index to read
- rvalid  out  1  read data valid
- rready  in  1  consumer takes rdata
- rdata  out  DATA_WIDTH  read data
- waddr  in  INDEX_WIDTH  write index
- wvalid  in  1  write-back beat, one per fragment, in order
- wstrb  in  1  commit wdata to memory
- wdata  in  DATA_WIDTH  write data
- wlast  in  1  last fragment of the primitive
- frame_done  out  1  one-cycle pulse after a wvalid&&wlast beat
- protocol_error  out  1  sticky: wvalid seen with empty scoreboard

Behaviour:
- Reset (async, active-high): req_tready, rvalid, clear_busy, frame_done and protocol_error = 0; rdata = 0; scoreboard empty; output FIFO empty; FSM = IDLE. Memory contents are not reset.
- Memory: synchronous read with 1-cycle latency; synchronous write; a single write port, shared by write-back and clear.
- Read path:
  - A request fires on req_tvalid && req_tready at edge N.
  - The memory read registers at N+1 into a 2-entry output FIFO.
  - rvalid is asserted from N+2, so minimum latency is 2.
  - rdata/rvalid stay stable until rready. An FIFO pop occurs on rvalid && rready.
- req_tready = FSM==IDLE && (FIFO occupancy + reads in memory stage) < 2 && scoreboard not full && no valid scoreboard entry equals req_tindex. It is combinational from state and req_tindex.
- Scoreboard: an in-order FIFO of indices.
  - Push req_tindex on accept.
  - Pop the head on every wvalid, regardless of wstrb.
  - Same-cycle push and pop: occupancy is unchanged.
  - The hazard compare uses pre-pop state. A request matching the entry being freed this cycle stalls one more cycle, which avoids a same-address read-during-write.
- Write: wvalid && wstrb -> mem[waddr] <= wdata. If wvalid arrives with an empty scoreboard, set protocol_error (sticky until reset) and do not pop.
- frame_done: registered pulse, high the cycle after wvalid && wlast.
- Clear FSM:
  - IDLE: on clear_start go to DRAIN and assert clear_busy.
  - DRAIN: wait until the scoreboard and output FIFO are empty, then go to CLEAR with counter = 0.
  - CLEAR: write confClearValue to mem[counter] each cycle and increment. At counter == 2**INDEX_WIDTH-1, write the last word and return to IDLE; clear_busy drops the same edge.
  - Clear takes exactly 2**INDEX_WIDTH cycles in CLEAR.
  - clear_start outside IDLE is ignored.
  - No requests are accepted in DRAIN or CLEAR. Write-backs are still accepted in DRAIN.
  - Reset during CLEAR returns to IDLE; memory contents are partially cleared and undefined.
- Counter wrap: the counter width is INDEX_WIDTH+1 so the terminal compare is unambiguous.

Decomposition:
- Shared package/include: FSM state encodings (IDLE, DRAIN, CLEAR); DATA_WIDTH presets for the color, depth and stencil channels.
- Sub-module: index_scoreboard, holding the in-order index FIFO with parallel match, full/empty and push/pop.
- The memory array and output FIFO stay inline.

Test Plan:
- Preload mem[5]=0xDEADBEEF; request index 5 at cycle 0 with rready=1 -> rvalid at cycle 2 with rdata=0xDEADBEEF; req_tready stays high.
- Request 7, then 7 again next cycle -> second request stalls. Send wvalid, waddr=7, wstrb=1, wdata=0x11 -> second request is accepted only the cycle after the pop and returns 0x11.
- Hold rready=0 and issue 4 distinct requests -> exactly 2 accepted, req_tready=0. Release rready -> data arrives in order, unchanged while stalled.
- Issue 4 outstanding requests with INFLIGHT_DEPTH=4 and no write-backs -> the 5th stalls. Send one wvalid with wstrb=0 -> the 5th is accepted and memory is unchanged.
- INDEX_WIDTH=4, confClearValue=0xA5, clear_start with 1 request in flight -> DRAIN until write-back, then 16 CLEAR cycles. Reads of all 16 indices return 0xA5. A second clear_start mid-clear is ignored.
- wvalid with empty scoreboard -> protocol_error=1 and stays 1. wvalid&&wlast -> frame_done pulses 1 cycle later. Assert reset mid-CLEAR -> clear_busy=0 and req_tready=0 immediately.
